conv_read_ctrl: RTL

- Parametrised feature-buffer read sequencer for the convolution engines; successor to the fixed 13/26-column 1x1 read controller.
- Walks a feature map of runtime-programmed columns x rows, repeated for a programmed number of channel passes.
- Produces read enable, linear buffer address, coordinate counters and a completion pulse.
- Adds downstream back-pressure, abort, zero-size handling and a base address. Sits between the Lite register block and the feature line buffer.

---
 rtl/conv_ctrl_pkg.sv | 27 ++
 rtl/conv_xyz_counter.sv | 77 +++++++
 rtl/conv_read_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_ctrl_pkg
// Description : Shared definitions for the convolution feature-buffer read
//               path: FSM state encoding, default widths and the column
//               counts of the fixed-size controller this block replaces.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_ctrl_pkg;

    // Read sequencer FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_READ = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Default field widths
    localparam int c_COL_W_DEF  = 9;
    localparam int c_ROW_W_DEF  = 7;
    localparam int c_CH_W_DEF   = 8;
    localparam int c_ADDR_W_DEF = 16;

    // Map widths supported by the old fixed 1x1 read controller
    localparam int c_COL_13 = 13;
    localparam int c_COL_26 = 26;

endpackage
`default_nettype wire

// File: rtl/conv_xyz_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv_xyz_counter
// Description : Cascaded column / row / channel-pass counter. Each enabled
//               cycle advances the column; the column wrap advances the row
//               and the row wrap advances the pass. All three wrap to 0 at
//               their programmed maxima.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_clr          - synchronous clear (dominates i_en)
//               i_en           - advance by one position
//               i_*_max        - last valid index per dimension (count - 1)
//               o_col/row/ch   - current position
//               o_map_wrap     - current position is the last pixel of a map
//               o_all_max      - current position is the last pixel of the job
// Revision    : 1.0 - initial release
// ============================================================================
module conv_xyz_counter
    import conv_ctrl_pkg::*;
#(
    parameter int COL_W = c_COL_W_DEF,
    parameter int ROW_W = c_ROW_W_DEF,
    parameter int CH_W  = c_CH_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [COL_W-1:0] i_col_max,
    input  logic [ROW_W-1:0] i_row_max,
    input  logic [CH_W-1:0]  i_ch_max,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic [CH_W-1:0]  o_ch,
    output logic             o_map_wrap,
    output logic             o_all_max
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [CH_W-1:0]  r_ch;
    logic             w_col_at_max;
    logic             w_row_at_max;
    logic             w_ch_at_max;

    assign w_col_at_max = (r_col == i_col_max);
    assign w_row_at_max = (r_row == i_row_max);
    assign w_ch_at_max  = (r_ch  == i_ch_max);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (i_en) begin
            if (w_col_at_max) begin
                r_col <= '0;
                if (w_row_at_max) begin
                    r_row <= '0;
                    // Final pass wraps to 0 so the counters sit at the origin after the job
                    r_ch  <= w_ch_at_max ? '0 : r_ch + CH_W'(1);
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_ch       = r_ch;
    assign o_map_wrap = w_col_at_max & w_row_at_max;
    assign o_all_max  = w_col_at_max & w_row_at_max & w_ch_at_max;

endmodule
`default_nettype wire

// File: rtl/conv_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_read_ctrl
// Description : Feature-buffer read sequencer. Walks col_num x row_num pixels
//               ch_pass times, issuing one buffer read per cycle in which
//               rd_ready is high, then pulses conv_read_finish.
// Ports       : sclk, s_rst                       - clock, sync reset
//               conv_start, conv_abort            - job control
//               col_num, row_num, ch_pass, base_addr - job geometry (at start)
//               rd_ready                          - downstream back-pressure
//               buffer_rd_en, rd_addr             - read strobe and address
//               col_cnt, row_cnt, ch_cnt, last_rd - position of current read
//               busy, conv_read_finish            - status
//               stall_cycles                      - only with CONV_READ_PERF_EN
// Options     : CONV_READ_PERF_EN adds the stall_cycles performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_read_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int COL_W  = c_COL_W_DEF,
    parameter int ROW_W  = c_ROW_W_DEF,
    parameter int CH_W   = c_CH_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              conv_start,
    input  logic              conv_abort,
    input  logic [COL_W-1:0]  col_num,
    input  logic [ROW_W-1:0]  row_num,
    input  logic [CH_W-1:0]   ch_pass,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              rd_ready,
    output logic              buffer_rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [COL_W-1:0]  col_cnt,
    output logic [ROW_W-1:0]  row_cnt,
    output logic [CH_W-1:0]   ch_cnt,
    output logic              last_rd,
    output logic              busy,
    output logic              conv_read_finish
`ifdef CONV_READ_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    logic [1:0]        r_state;
    logic [COL_W-1:0]  r_col_num;
    logic [ROW_W-1:0]  r_row_num;
    logic [CH_W-1:0]   r_ch_pass;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_rd_addr;

    logic w_rd_en;
    logic w_start_ok;
    logic w_zero_size;
    logic w_map_wrap;
    logic w_all_max;

    assign w_rd_en     = (r_state == c_ST_READ) & rd_ready;
    assign w_start_ok  = (r_state == c_ST_IDLE) & conv_start;
    assign w_zero_size = (col_num == '0) | (row_num == '0) | (ch_pass == '0);

    // Maxima come from the shadow copies, so they only matter once READ is
    // entered, by which time the shadows are nonzero.
    conv_xyz_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .CH_W  (CH_W)
    ) u_xyz (
        .clk        (sclk),
        .rst        (s_rst),
        .i_clr      (conv_abort | w_start_ok),
        .i_en       (w_rd_en),
        .i_col_max  (r_col_num - COL_W'(1)),
        .i_row_max  (r_row_num - ROW_W'(1)),
        .i_ch_max   (r_ch_pass - CH_W'(1)),
        .o_col      (col_cnt),
        .o_row      (row_cnt),
        .o_ch       (ch_cnt),
        .o_map_wrap (w_map_wrap),
        .o_all_max  (w_all_max)
    );

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_state   <= c_ST_IDLE;
            r_col_num <= '0;
            r_row_num <= '0;
            r_ch_pass <= '0;
            r_base    <= '0;
            r_rd_addr <= '0;
        end else if (conv_abort) begin
            // Shadows are kept; the next start reloads them anyway
            r_state   <= c_ST_IDLE;
            r_rd_addr <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (conv_start) begin
                        r_col_num <= col_num;
                        r_row_num <= row_num;
                        r_ch_pass <= ch_pass;
                        r_base    <= base_addr;
                        r_rd_addr <= base_addr;
                        r_state   <= w_zero_size ? c_ST_DONE : c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    if (w_rd_en) begin
                        // Every pass rereads the same map from its base
                        r_rd_addr <= w_map_wrap ? r_base : r_rd_addr + ADDR_W'(1);
                        if (w_all_max) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef CONV_READ_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_stall_cycles <= '0;
        end else if (!conv_abort) begin
            if (w_start_ok) begin
                r_stall_cycles <= '0;
            end else if ((r_state == c_ST_READ) && !rd_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign buffer_rd_en     = w_rd_en;
    assign rd_addr          = r_rd_addr;
    assign last_rd          = w_rd_en & w_all_max;
    assign busy             = (r_state == c_ST_READ) | (r_state == c_ST_DONE);
    assign conv_read_finish = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
